pe_array_mac: RTL
=================

PE_ARRAY_MAC -- requirements
Module: pe_array_mac

Interface
REQ-001 SHALL have parameter ROWS, default 2: weight rows, one per output row.
REQ-002 SHALL have parameter COLS, default 16: input-matrix elements per beat, one per output column.
REQ-003 SHALL have parameter DATA_W, default 16: signed fixed-point operand and result width.
REQ-004 SHALL have parameter FRAC_BITS, default 9: fractional bits of operands and result (Q7.9 at defaults).
REQ-005 SHALL have parameter MAX_K, default 16: maximum beats accumulated per tile.
REQ-006 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-007 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port in_valid, input, 1: operand beat valid.
REQ-009 SHALL have port in_ready, output, 1: beat accepted when in_valid && in_ready.
REQ-010 SHALL have port data_input_matrix, input, COLS*DATA_W: element n at bits [n*DATA_W +: DATA_W].
REQ-011 SHALL have port data_weight_matrix, input, ROWS*DATA_W: element m at bits [m*DATA_W +: DATA_W].
REQ-012 SHALL have port k_len, input, $clog2(MAX_K+1): beats in the tile; sampled on the first beat only.
REQ-013 SHALL have port out_valid, output, 1: result tile valid.
REQ-014 SHALL have port out_ready, input, 1: result consumed when out_valid && out_ready.
REQ-015 SHALL have port pe_array_out, output, [ROWS][COLS][DATA_W]: result element [m][n].
REQ-016 SHALL have port sat_flag, output, 1: at least one element of the current result saturated.

Function
REQ-017 SHALL implement states IDLE, ACCUM, ROUND, OUT.
REQ-018 in_ready SHALL be 1 in IDLE and ACCUM and 0 in ROUND and OUT.
REQ-019 On every accepted beat, acc[m][n] SHALL increase by the signed full-precision product data_input[n]*data_weight[m] (2*DATA_W bits).
REQ-020 Accumulators SHALL be 2*DATA_W+$clog2(MAX_K) bits signed and never wrap.
REQ-021 A k_len of 0 SHALL be treated as 1; a k_len greater than MAX_K SHALL be treated as MAX_K.
REQ-022 A beat counter SHALL count accepted beats; IDLE->ACCUM on the first beat when k>1; IDLE or ACCUM->ROUND on the beat that makes count equal k.
REQ-023 Gaps in in_valid during ACCUM SHALL stall accumulation without loss or duplication.
REQ-024 ROUND SHALL last exactly one cycle and compute (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS (arithmetic shift, round half up), then saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-025 The rounded, saturated result and sat_flag SHALL be registered at ROUND exit; out_valid SHALL rise 2 cycles after the last beat is accepted.
REQ-026 In OUT, pe_array_out, sat_flag and out_valid SHALL hold stable until out_ready=1.
REQ-027 On the output handshake, the block SHALL clear all accumulators and the counter, drop out_valid and return to IDLE, with in_ready=1 on the next cycle.
REQ-028 in_valid asserted while in_ready=0 SHALL have no effect.
REQ-029 pe_array_out SHALL retain the last result after the handshake until the next ROUND overwrites it.

Reset
REQ-030 While rst_n=0, the block SHALL be in IDLE with in_ready=1, out_valid=0, sat_flag=0, pe_array_out all zero, and accumulators and counter zero.
REQ-031 Reset asserted mid-tile or during OUT SHALL discard partial sums and any pending result immediately.

Verification
REQ-032 The bench SHALL check reset: release rst_n -> in_ready=1, out_valid=0, all outputs 0x0000.
REQ-033 The bench SHALL check single beat: k_len=1, all inputs 0x0200 (1.0), weights 0x0400 (2.0) -> every element 0x0400, out_valid 2 cycles after the beat, sat_flag=0.
REQ-034 The bench SHALL check accumulate and rounding: k_len=4, inputs 0x0100 (0.5), weights 0xFE00 (-1.0) -> every element 0xFC00; separately, k_len=1, input 0x0001, weight 0x0100 -> 0x0001 (half rounded up).
REQ-035 The bench SHALL check saturation: k_len=2, all inputs and weights 0x7000 (56.0) -> every element 0x7FFF and sat_flag=1; same values with weights 0x9000 (-56.0) -> 0x8000.
REQ-036 The bench SHALL check backpressure: out_ready=0 for 5 cycles with in_valid=1 -> outputs stable, in_ready=0, no beats consumed; out_ready=1 -> IDLE and in_ready=1 the next cycle.
REQ-037 The bench SHALL check mid-tile reset: k_len=4, reset after 2 beats, then tile k_len=1 with 0x0200 x 0x0200 -> every element 0x0200 (no residue).

Source files
------------

// File: rtl/pe_array_mac.sv
// pe_array_mac: ROWS x COLS grid of signed fixed-point multiply-accumulate cells.
// Each accepted beat adds data_input[n] * data_weight[m] into accumulator [m][n].
// After k beats the grid is rounded (half up), saturated to DATA_W bits and
// presented as one result tile with a valid/ready handshake.

module pe_array_mac #(
  parameter int ROWS      = 2,
  parameter int COLS      = 16,
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 9,
  parameter int MAX_K     = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [COLS*DATA_W-1:0]                 data_input_matrix,
  input  logic [ROWS*DATA_W-1:0]                 data_weight_matrix,
  input  logic [$clog2(MAX_K+1)-1:0]             k_len,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [ROWS-1:0][COLS-1:0][DATA_W-1:0]  pe_array_out,
  output logic                                   sat_flag
);

  // Counter width covers 0..MAX_K; accumulator headroom covers MAX_K full products.
  localparam int K_W   = $clog2(MAX_K + 1);
  localparam int SH_W  = $clog2(MAX_K);
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W = PROD_W + SH_W;

  // Rounding is done one bit wider than the accumulator so the bias can never overflow.
  localparam logic signed [ACC_W:0] ROUND_BIAS = (ACC_W+1)'(1) << (FRAC_BITS - 1);
  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W + 2 - DATA_W){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(ACC_W + 2 - DATA_W){1'b1}}, {(DATA_W - 1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t                       state;
  logic [K_W-1:0]               count;
  logic [K_W-1:0]               count_next;
  logic [K_W-1:0]               k_tile;
  logic [K_W-1:0]               k_clamped;
  logic                         beat_fire;

  logic signed [ACC_W-1:0]      acc      [ROWS][COLS];
  logic signed [ACC_W-1:0]      prod_ext [ROWS][COLS];

  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] round_val;
  logic                                  any_sat;

  assign beat_fire  = in_valid && in_ready;
  assign count_next = count + K_W'(1);

  // Tile length as seen by the counter: 0 means one beat, anything above MAX_K is capped.
  always_comb begin
    k_clamped = k_len;
    if (k_len == '0) begin
      k_clamped = K_W'(1);
    end else if (k_len > K_W'(MAX_K)) begin
      k_clamped = K_W'(MAX_K);
    end
  end

  // Full-precision signed products, sign-extended to accumulator width.
  always_comb begin
    logic signed [PROD_W-1:0] p;
    p = '0;
    for (int m = 0; m < ROWS; m++) begin
      for (int n = 0; n < COLS; n++) begin
        p = $signed(data_input_matrix[n*DATA_W +: DATA_W]) *
            $signed(data_weight_matrix[m*DATA_W +: DATA_W]);
        prod_ext[m][n] = ACC_W'(p);
      end
    end
  end

  // Round half up by biasing then arithmetic shift, then clamp into the DATA_W range.
  always_comb begin
    logic signed [ACC_W:0] biased;
    logic signed [ACC_W:0] shifted;
    biased    = '0;
    shifted   = '0;
    round_val = '0;
    any_sat   = 1'b0;
    for (int m = 0; m < ROWS; m++) begin
      for (int n = 0; n < COLS; n++) begin
        biased  = $signed({acc[m][n][ACC_W-1], acc[m][n]}) + ROUND_BIAS;
        shifted = biased >>> FRAC_BITS;
        if (shifted > SAT_MAX) begin
          round_val[m][n] = SAT_MAX[DATA_W-1:0];
          any_sat         = 1'b1;
        end else if (shifted < SAT_MIN) begin
          round_val[m][n] = SAT_MIN[DATA_W-1:0];
          any_sat         = 1'b1;
        end else begin
          round_val[m][n] = shifted[DATA_W-1:0];
        end
      end
    end
  end

  // Tile sequencer: accumulate beats, round once, hold the result until it is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      count        <= '0;
      k_tile       <= K_W'(1);
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      sat_flag     <= 1'b0;
      pe_array_out <= '0;
      for (int m = 0; m < ROWS; m++) begin
        for (int n = 0; n < COLS; n++) begin
          acc[m][n] <= '0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          if (beat_fire) begin
            for (int m = 0; m < ROWS; m++) begin
              for (int n = 0; n < COLS; n++) begin
                acc[m][n] <= acc[m][n] + prod_ext[m][n];
              end
            end
            count  <= K_W'(1);
            k_tile <= k_clamped;
            if (k_clamped == K_W'(1)) begin
              state    <= ROUND;
              in_ready <= 1'b0;
            end else begin
              state <= ACCUM;
            end
          end
        end

        ACCUM: begin
          if (beat_fire) begin
            for (int m = 0; m < ROWS; m++) begin
              for (int n = 0; n < COLS; n++) begin
                acc[m][n] <= acc[m][n] + prod_ext[m][n];
              end
            end
            count <= count_next;
            if (count_next == k_tile) begin
              state    <= ROUND;
              in_ready <= 1'b0;
            end
          end
        end

        ROUND: begin
          pe_array_out <= round_val;
          sat_flag     <= any_sat;
          out_valid    <= 1'b1;
          state        <= OUT;
        end

        OUT: begin
          if (out_ready) begin
            for (int m = 0; m < ROWS; m++) begin
              for (int n = 0; n < COLS; n++) begin
                acc[m][n] <= '0;
              end
            end
            count     <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
